// File: rtl/wb_register_bank_pkg.sv
// Shared widths and writeback source encodings for the MEM/WB consumer
// and the forwarding unit.
package wb_register_bank_pkg;

    localparam int NB_DATA       = 32;
    localparam int NB_REG        = 5;
    localparam int N_REGS        = 2 ** NB_REG;
    localparam int NB_MEM_TO_REG = 2;
    localparam int NB_COUNT      = 32;
    localparam int NB_PC         = 16;

    typedef enum logic [NB_MEM_TO_REG-1:0] {
        MEM_TO_REG_ALU = 2'b00,
        MEM_TO_REG_MEM = 2'b01,
        MEM_TO_REG_PC  = 2'b10,
        MEM_TO_REG_INM = 2'b11
    } mem_to_reg_e;

    function automatic logic [NB_DATA-1:0] zero_ext_pc(input logic [NB_PC-1:0] pc);
        return {{(NB_DATA - NB_PC){1'b0}}, pc};
    endfunction

endpackage

// File: rtl/wb_register_bank_if.sv
// MEM/WB latch fields, ID/debug read ports and status outputs of the
// writeback register bank.
interface wb_register_bank_if;
    import wb_register_bank_pkg::*;

    logic                     i_enable_pipe;
    logic                     i_reg_write;
    logic [NB_REG-1:0]        i_write_register;
    logic [NB_MEM_TO_REG-1:0] i_mem_to_reg;
    logic [NB_DATA-1:0]       i_mem_data;
    logic [NB_DATA-1:0]       i_alu_result;
    logic [NB_PC-1:0]         i_pc;
    logic [NB_DATA-1:0]       i_inm_ext;
    logic                     i_halt_detected;
    logic [NB_REG-1:0]        i_read_reg_a;
    logic [NB_REG-1:0]        i_read_reg_b;
    logic [NB_REG-1:0]        i_debug_reg;
    logic [NB_DATA-1:0]       o_read_data_a;
    logic [NB_DATA-1:0]       o_read_data_b;
    logic [NB_DATA-1:0]       o_debug_data;
    logic [NB_DATA-1:0]       o_wb_data;
    logic [NB_COUNT-1:0]      o_retired_count;
    logic                     o_program_done;

    modport master (
        output i_enable_pipe, i_reg_write, i_write_register, i_mem_to_reg,
               i_mem_data, i_alu_result, i_pc, i_inm_ext, i_halt_detected,
               i_read_reg_a, i_read_reg_b, i_debug_reg,
        input  o_read_data_a, o_read_data_b, o_debug_data, o_wb_data,
               o_retired_count, o_program_done
    );

    modport slave (
        input  i_enable_pipe, i_reg_write, i_write_register, i_mem_to_reg,
               i_mem_data, i_alu_result, i_pc, i_inm_ext, i_halt_detected,
               i_read_reg_a, i_read_reg_b, i_debug_reg,
        output o_read_data_a, o_read_data_b, o_debug_data, o_wb_data,
               o_retired_count, o_program_done
    );

endinterface

// File: rtl/wb_source_mux.sv
// Combinational 4:1 writeback source select; also instantiated by the
// forwarding unit so both agree on the value being written back.
module wb_source_mux
    import wb_register_bank_pkg::*;
(
    input  logic [NB_MEM_TO_REG-1:0] i_sel,
    input  logic [NB_DATA-1:0]       i_alu_result,
    input  logic [NB_DATA-1:0]       i_mem_data,
    input  logic [NB_PC-1:0]         i_pc,
    input  logic [NB_DATA-1:0]       i_inm_ext,
    output logic [NB_DATA-1:0]       o_wb_data
);

    always_comb begin
        o_wb_data = i_alu_result;
        case (i_sel)
            MEM_TO_REG_ALU: o_wb_data = i_alu_result;
            MEM_TO_REG_MEM: o_wb_data = i_mem_data;
            MEM_TO_REG_PC:  o_wb_data = zero_ext_pc(i_pc);
            MEM_TO_REG_INM: o_wb_data = i_inm_ext;
            default:        o_wb_data = i_alu_result;
        endcase
    end

endmodule

// File: rtl/wb_register_bank.sv
// Writeback stage: commits the selected MEM/WB value into the register file,
// serves bypassed ID reads and a debug read, and tracks retired cycles/HALT.
module wb_register_bank
    import wb_register_bank_pkg::*;
(
    input  logic             i_clock,
    input  logic             i_reset,
    wb_register_bank_if.slave bus
);

    logic [NB_DATA-1:0]  regs_q [N_REGS];
    logic [NB_DATA-1:0]  regs_d [N_REGS];
    logic [NB_COUNT-1:0] count_q;
    logic [NB_COUNT-1:0] count_d;
    logic                done_q;
    logic                done_d;
    logic                commit;
    logic                advance;
    logic [NB_DATA-1:0]  wb_data;

    wb_source_mux u_wb_source_mux (
        .i_sel        (bus.i_mem_to_reg),
        .i_alu_result (bus.i_alu_result),
        .i_mem_data   (bus.i_mem_data),
        .i_pc         (bus.i_pc),
        .i_inm_ext    (bus.i_inm_ext),
        .o_wb_data    (wb_data)
    );

    // r0 is never written, so its storage stays at its reset value of zero.
    always_comb begin
        advance = bus.i_enable_pipe & ~done_q;
        commit  = advance & bus.i_reg_write & (bus.i_write_register != '0);
    end

    // The counter samples the pre-set done flag, so the HALT cycle is counted.
    always_comb begin
        regs_d  = regs_q;
        count_d = count_q;
        done_d  = done_q;
        if (commit) begin
            regs_d[bus.i_write_register] = wb_data;
        end
        if (advance) begin
            count_d = count_q + NB_COUNT'(1);
        end
        if (bus.i_enable_pipe & bus.i_halt_detected) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        bus.o_read_data_a = regs_q[bus.i_read_reg_a];
        bus.o_read_data_b = regs_q[bus.i_read_reg_b];
        if (commit && (bus.i_read_reg_a == bus.i_write_register)) begin
            bus.o_read_data_a = wb_data;
        end
        if (commit && (bus.i_read_reg_b == bus.i_write_register)) begin
            bus.o_read_data_b = wb_data;
        end
    end

    assign bus.o_debug_data    = regs_q[bus.i_debug_reg];
    assign bus.o_wb_data       = wb_data;
    assign bus.o_retired_count = count_q;
    assign bus.o_program_done  = done_q;

endmodule

// File: tb/tb_wb_register_bank.sv
// Directed self-checking bench for wb_register_bank: reset, source select,
// r0 protection, bypass, enable gating and HALT freeze.
module tb_wb_register_bank;
    import wb_register_bank_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   exp_count;

    wb_register_bank_if bus ();

    wb_register_bank dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic wr, input logic [NB_REG-1:0] rd,
                                 input logic [NB_MEM_TO_REG-1:0] sel, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic [NB_PC-1:0] pc,
                                 input logic [31:0] inm, input logic halt);
        bus.i_enable_pipe    = en;
        bus.i_reg_write      = wr;
        bus.i_write_register = rd;
        bus.i_mem_to_reg     = sel;
        bus.i_alu_result     = alu;
        bus.i_mem_data       = mem;
        bus.i_pc             = pc;
        bus.i_inm_ext        = inm;
        bus.i_halt_detected  = halt;
    endtask

    // Outputs are sampled 1ns after the rising edge, well clear of it.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sel_expected [4];

    initial begin
        checks    = 0;
        failures  = 0;
        exp_count = 0;
        sel_expected[0] = 32'hA5A5_A5A5;
        sel_expected[1] = 32'h0000_0011;
        sel_expected[2] = 32'h0000_0040;
        sel_expected[3] = 32'hFFFF_0000;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 16'h0, 32'h0, 1'b0);
        bus.i_read_reg_a = 5'd0;
        bus.i_read_reg_b = 5'd0;
        bus.i_debug_reg  = 5'd5;
        #2;
        checkOutput("reset_count", bus.o_retired_count, 32'd0);
        checkOutput("reset_done", {31'd0, bus.o_program_done}, 32'd0);
        checkOutput("reset_r5", bus.o_debug_data, 32'd0);
        #10 rst = 1'b0;

        $display("[TB] write r5 then asynchronous reset with a write pending");
        applyStimulus(1'b1, 1'b1, 5'd5, 2'd0, 32'h1234, 32'h0, 16'h0, 32'h0, 1'b0);
        stepClock();
        checkOutput("r5_written", bus.o_debug_data, 32'h1234);
        checkOutput("count_one", bus.o_retired_count, 32'd1);
        applyStimulus(1'b1, 1'b1, 5'd6, 2'd0, 32'h99, 32'h0, 16'h0, 32'h0, 1'b0);
        bus.i_read_reg_a = 5'd5;
        #2 rst = 1'b1;
        #1;
        checkOutput("async_r5_debug", bus.o_debug_data, 32'd0);
        checkOutput("async_r5_porta", bus.o_read_data_a, 32'd0);
        checkOutput("async_count", bus.o_retired_count, 32'd0);
        checkOutput("async_done", {31'd0, bus.o_program_done}, 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 16'h0, 32'h0, 1'b0);
        #1 rst = 1'b0;
        bus.i_debug_reg = 5'd6;
        stepClock();
        checkOutput("inflight_r6_dropped", bus.o_debug_data, 32'd0);
        checkOutput("count_after_reset", bus.o_retired_count, 32'd0);

        $display("[TB] writeback source select into r3");
        bus.i_debug_reg = 5'd3;
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b1, 1'b1, 5'd3, 2'(s), 32'hA5A5_A5A5, 32'h11, 16'h0040, 32'hFFFF_0000, 1'b0);
            #1;
            checkOutput($sformatf("wb_data_sel%0d", s), bus.o_wb_data, sel_expected[s]);
            stepClock();
            exp_count++;
            checkOutput($sformatf("r3_sel%0d", s), bus.o_debug_data, sel_expected[s]);
        end
        checkOutput("count_after_sel", bus.o_retired_count, 32'(exp_count));

        $display("[TB] r0 protection");
        bus.i_read_reg_a = 5'd0;
        bus.i_debug_reg  = 5'd0;
        applyStimulus(1'b1, 1'b1, 5'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 16'h0, 32'h0, 1'b0);
        #1;
        checkOutput("r0_porta_pre", bus.o_read_data_a, 32'd0);
        stepClock();
        exp_count++;
        checkOutput("r0_porta_post", bus.o_read_data_a, 32'd0);
        checkOutput("r0_debug_post", bus.o_debug_data, 32'd0);

        $display("[TB] same-cycle write bypass on r7");
        bus.i_read_reg_a = 5'd7;
        bus.i_read_reg_b = 5'd3;
        bus.i_debug_reg  = 5'd7;
        applyStimulus(1'b1, 1'b1, 5'd7, 2'd0, 32'h55, 32'h0, 16'h0, 32'h0, 1'b0);
        #1;
        checkOutput("bypass_porta", bus.o_read_data_a, 32'h55);
        checkOutput("nobypass_portb_r3", bus.o_read_data_b, 32'hFFFF_0000);
        checkOutput("bypass_debug_old", bus.o_debug_data, 32'd0);
        stepClock();
        exp_count++;
        checkOutput("r7_committed", bus.o_debug_data, 32'h55);

        $display("[TB] enable gating on r2");
        bus.i_read_reg_a = 5'd2;
        bus.i_debug_reg  = 5'd2;
        applyStimulus(1'b0, 1'b1, 5'd2, 2'd0, 32'h9, 32'h0, 16'h0, 32'h0, 1'b0);
        #1;
        checkOutput("gated_no_bypass", bus.o_read_data_a, 32'd0);
        repeat (3) stepClock();
        checkOutput("gated_r2", bus.o_debug_data, 32'd0);
        checkOutput("gated_count", bus.o_retired_count, 32'(exp_count));
        applyStimulus(1'b1, 1'b1, 5'd2, 2'd0, 32'h9, 32'h0, 16'h0, 32'h0, 1'b0);
        stepClock();
        exp_count++;
        checkOutput("enabled_r2", bus.o_debug_data, 32'h9);
        checkOutput("enabled_count", bus.o_retired_count, 32'(exp_count));

        $display("[TB] HALT retires and freezes the bank");
        applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 16'h0, 32'h0, 1'b0);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 16'h0, 32'h0, 1'b0);
        repeat (10) stepClock();
        checkOutput("pre_halt_count", bus.o_retired_count, 32'd10);
        checkOutput("pre_halt_done", {31'd0, bus.o_program_done}, 32'd0);
        bus.i_debug_reg = 5'd4;
        applyStimulus(1'b1, 1'b1, 5'd4, 2'd0, 32'h77, 32'h0, 16'h0, 32'h0, 1'b1);
        stepClock();
        checkOutput("halt_count", bus.o_retired_count, 32'd11);
        checkOutput("halt_done", {31'd0, bus.o_program_done}, 32'd1);
        checkOutput("halt_r4", bus.o_debug_data, 32'h77);
        bus.i_read_reg_a = 5'd4;
        applyStimulus(1'b1, 1'b1, 5'd4, 2'd0, 32'h88, 32'h0, 16'h0, 32'h0, 1'b0);
        #1;
        checkOutput("done_no_bypass", bus.o_read_data_a, 32'h77);
        checkOutput("done_wb_data", bus.o_wb_data, 32'h88);
        repeat (2) stepClock();
        checkOutput("frozen_r4", bus.o_debug_data, 32'h77);
        checkOutput("frozen_count", bus.o_retired_count, 32'd11);
        checkOutput("sticky_done", {31'd0, bus.o_program_done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_register_bank.md
Name: wb_register_bank

Overview:
Consumer end of the MEM/WB pipeline latch. Selects the writeback value from the latched MEM/WB fields and commits it to the 32x32 general-purpose register file. Serves the two ID-stage read ports with same-cycle write bypass and a debug read port. Also keeps a retired-cycle counter and a sticky program-done flag that the debug unit polls.

Parameters:
NB_DATA, 32, register/data width
NB_REG, 5, register address width
N_REGS, 32, number of registers (2**NB_REG)
NB_MEM_TO_REG, 2, writeback source select width
NB_COUNT, 32, retired-cycle counter width

Ports:
i_clock  in  1  system clock; the register file writes on posedge, half a cycle after the negedge-updated MEM/WB latch
i_reset  in  1  asynchronous, active-high reset
i_enable_pipe  in  1  pipeline advance enable, same signal as the latches use
i_reg_write  in  1  latched write enable from MEM/WB
i_write_register  in  NB_REG  latched destination register
i_mem_to_reg  in  NB_MEM_TO_REG  latched writeback source select
i_mem_data  in  NB_DATA  latched load data
i_alu_result  in  NB_DATA  latched ALU result
i_pc  in  `ADDRWIDTH  latched link PC, zero-extended to NB_DATA
i_inm_ext  in  NB_DATA  latched LUI immediate
i_halt_detected  in  1  latched HALT marker
i_read_reg_a  in  NB_REG  ID read address A
i_read_reg_b  in  NB_REG  ID read address B
i_debug_reg  in  NB_REG  debug read address
o_read_data_a  out  NB_DATA  ID read data A
o_read_data_b  out  NB_DATA  ID read data B
o_debug_data  out  NB_DATA  debug read data, no bypass
o_wb_data  out  NB_DATA  selected writeback value, combinational, feeds forwarding
o_retired_count  out  NB_COUNT  number of enabled, not-done cycles
o_program_done  out  1  sticky HALT-retired flag

Behaviour:
- Source select (combinational): 00 selects i_alu_result, 01 selects i_mem_data, 10 selects {zero-extend, i_pc}, 11 selects i_inm_ext.
- Commit condition: commit = i_enable_pipe & i_reg_write & ~o_program_done & (i_write_register != 0).
- On posedge with commit, regs[i_write_register] <= o_wb_data. Latency is one cycle from a stable latch output to the register holding the value.
- Register 0 always reads 0. Writes to register 0 are dropped.
- Read ports A and B are combinational. If commit is true and the read address equals i_write_register (nonzero), the port returns o_wb_data (write-before-read bypass). Otherwise it returns the stored value.
- The debug port is combinational from storage only, with no bypass.
- Retired counter: on posedge, increments by 1 when i_enable_pipe & ~o_program_done. It wraps modulo 2**NB_COUNT.
- Done flag:
  - Set on posedge when i_enable_pipe & i_halt_detected.
  - Cleared only by reset.
  - The HALT cycle itself is counted, because the counter samples the pre-set flag.
- i_enable_pipe low: no writes, no count, no done update. The latch is holding, so this is idempotent stepping.
- Reset (asynchronous, immediate, any time including mid-write):
  - All registers clear to 0.
  - o_retired_count clears to 0.
  - o_program_done clears to 0.
  - An in-flight write is discarded.
- Simultaneous HALT and reg_write in the same cycle: the write commits, because done is still 0 that cycle. All later writes are blocked.

Decomposition:
- Add the mem_to_reg encodings (MEM_TO_REG_ALU=2'b00, MEM, PC, INM) to the shared parameters.vh, alongside `ADDRWIDTH.
- One sub-module, wb_source_mux: the combinational 4:1 source select, reused by the forwarding unit.

Test Plan:
- Reset mid-run: after writing r5=0x1234, pulse i_reset asynchronously between edges. All registers, the count and done read 0 immediately.
- Source select: enable=1, reg_write=1, rd=3.
  - sel=00 with alu=0xA5A5A5A5 -> r3=0xA5A5A5A5.
  - sel=01 with mem=0x11 -> r3=0x11.
  - sel=10 with pc=0x40 -> r3=0x40.
  - sel=11 with inm=0xFFFF0000 -> r3=0xFFFF0000.
- r0 protection: write 0xDEADBEEF to rd=0. Port A at address 0 and the debug port at address 0 both read 0.
- Bypass: write rd=7 with 0x55 while read_reg_a=7 in the same cycle. o_read_data_a=0x55 before the edge, and the debug port at 7 still shows the old value 0.
- Enable gating: hold enable=0 with reg_write=1, rd=2, alu=0x9 for 3 edges. r2 stays 0 and the count does not change. Raising enable for 1 edge gives r2=0x9 and count+1.
- HALT: 10 enabled cycles, then halt=1 together with reg_write to rd=4 (0x77). Required result: count=11, done=1, r4=0x77. Further writes to rd=4 are ignored and the count stays frozen.
